// File: rtl/pio_pkg.sv
// rtl/pio_pkg.sv - shared IRQ arbiter defaults, wait FSM encoding, relative index helper
package pio_pkg;

    localparam int NUM_SM_DEFAULT  = 4;
    localparam int NUM_IRQ_DEFAULT = 8;

    typedef enum logic {
        IDLE     = 1'b0,
        WAIT_CLR = 1'b1
    } wait_state_e;

    // Relative flag number: bit2 is kept, the low two bits rotate by machine number.
    function automatic logic [2:0] rel_index(input logic [2:0] idx, input logic [1:0] sm_num);
        rel_index = {idx[2], idx[1:0] + sm_num};
    endfunction

endpackage

// File: rtl/irq_wait_fsm.sv
// rtl/irq_wait_fsm.sv - per-machine set-and-wait tracker
// Ports:
//   clk, reset       : clock, synchronous active-high reset
//   start            : accepted set-and-wait request this cycle
//   start_idx        : resolved flag number to wait on
//   irq_flags        : registered flag state from the arbiter
//   stall            : high while waiting for the latched flag to clear
module irq_wait_fsm
    import pio_pkg::*;
#(
    parameter int NUM_IRQ = NUM_IRQ_DEFAULT
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [2:0]         start_idx,
    input  logic [NUM_IRQ-1:0] irq_flags,
    output logic               stall
);

    wait_state_e state_q, state_d;
    logic [2:0]  idx_q, idx_d;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = WAIT_CLR;
                    idx_d   = start_idx;
                end
            end
            WAIT_CLR: begin
                // Release only once the registered flag reads back as clear.
                if (!irq_flags[idx_q]) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    assign stall = (state_q == WAIT_CLR);

endmodule

// File: rtl/irq_arbiter.sv
// rtl/irq_arbiter.sv - shared IRQ flag arbiter for NUM_SM state machines
// Optional feature macro: IRQ_REL_EN (relative flag addressing via irq_idx[4]).
// Ports:
//   clk, reset  : clock, synchronous active-high reset
//   irq_req     : per-machine IRQ instruction strobe
//   irq_clr     : per-machine 1 = clear, 0 = set
//   irq_wait    : per-machine set-and-wait
//   irq_idx     : per-machine 5-bit index (bit4 relative, bits2:0 flag)
//   host_clr    : host write-1-to-clear strobes
//   irq_inten   : host interrupt enable for flags 3:0
//   irq_flags   : registered flag state
//   irq_stall   : per-machine stall during set-and-wait
//   irq_out     : host interrupt
module irq_arbiter
    import pio_pkg::*;
#(
    parameter int NUM_SM  = NUM_SM_DEFAULT,
    parameter int NUM_IRQ = NUM_IRQ_DEFAULT
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_SM-1:0]   irq_req,
    input  logic [NUM_SM-1:0]   irq_clr,
    input  logic [NUM_SM-1:0]   irq_wait,
    input  logic [5*NUM_SM-1:0] irq_idx,
    input  logic [NUM_IRQ-1:0]  host_clr,
    input  logic [3:0]          irq_inten,
    output logic [NUM_IRQ-1:0]  irq_flags,
    output logic [NUM_SM-1:0]   irq_stall,
    output logic                irq_out
);

    logic [NUM_IRQ-1:0] flags_q, flags_d;
    logic [NUM_IRQ-1:0] set_vec, clr_vec;
    logic [2:0]         tgt [NUM_SM];
    logic [NUM_SM-1:0]  req_live;
    logic               unused_idx_bits;

    // A stalled machine cannot issue; drop anything seen on its strobe.
    assign req_live        = irq_req & ~irq_stall;
    assign unused_idx_bits = ^irq_idx;

    always_comb begin
        for (int i = 0; i < NUM_SM; i++) begin
`ifdef IRQ_REL_EN
            tgt[i] = irq_idx[5*i+4] ? rel_index(irq_idx[5*i +: 3], 2'(i)) : irq_idx[5*i +: 3];
`else
            tgt[i] = irq_idx[5*i +: 3];
`endif
        end
    end

    // Sets and clears are OR-reduced per flag, so duplicates collapse; set dominates.
    always_comb begin
        set_vec = '0;
        clr_vec = host_clr;
        for (int i = 0; i < NUM_SM; i++) begin
            for (int j = 0; j < NUM_IRQ; j++) begin
                if (req_live[i] && (int'(tgt[i]) == j)) begin
                    if (irq_clr[i]) begin
                        clr_vec[j] = 1'b1;
                    end else begin
                        set_vec[j] = 1'b1;
                    end
                end
            end
        end
        flags_d = set_vec | (flags_q & ~clr_vec);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            flags_q <= '0;
        end else begin
            flags_q <= flags_d;
        end
    end

    for (genvar g = 0; g < NUM_SM; g++) begin : g_wait
        irq_wait_fsm #(
            .NUM_IRQ (NUM_IRQ)
        ) u_wait_fsm (
            .clk       (clk),
            .reset     (reset),
            .start     (req_live[g] & ~irq_clr[g] & irq_wait[g]),
            .start_idx (tgt[g]),
            .irq_flags (flags_q),
            .stall     (irq_stall[g])
        );
    end

    assign irq_flags = flags_q;
    assign irq_out   = |(flags_q[3:0] & irq_inten);

endmodule

// File: tb/tb_irq_arbiter.sv
// tb/tb_irq_arbiter.sv - scoreboard bench for irq_arbiter
module tb_irq_arbiter;

    localparam int NUM_SM  = 4;
    localparam int NUM_IRQ = 8;

    logic                clk = 1'b0;
    logic                reset;
    logic [NUM_SM-1:0]   irq_req;
    logic [NUM_SM-1:0]   irq_clr;
    logic [NUM_SM-1:0]   irq_wait;
    logic [5*NUM_SM-1:0] irq_idx;
    logic [NUM_IRQ-1:0]  host_clr;
    logic [3:0]          irq_inten;
    logic [NUM_IRQ-1:0]  irq_flags;
    logic [NUM_SM-1:0]   irq_stall;
    logic                irq_out;

    typedef struct packed {
        logic [7:0] f;
        logic [3:0] s;
        logic       o;
    } exp_t;

    exp_t       exp_q[$];
    int         n_vec = 0;
    int         n_err = 0;
    logic [7:0] m_flags = '0;
    logic [3:0] m_wait  = '0;
    logic [2:0] m_idx [4];

    always #5 clk = ~clk;

    irq_arbiter #(
        .NUM_SM  (NUM_SM),
        .NUM_IRQ (NUM_IRQ)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .irq_req   (irq_req),
        .irq_clr   (irq_clr),
        .irq_wait  (irq_wait),
        .irq_idx   (irq_idx),
        .host_clr  (host_clr),
        .irq_inten (irq_inten),
        .irq_flags (irq_flags),
        .irq_stall (irq_stall),
        .irq_out   (irq_out)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [2:0] tb_tgt(input int s, input logic [4:0] idx);
`ifdef IRQ_REL_EN
        if (idx[4]) return {idx[2], 2'(idx[1:0] + 2'(s))};
`endif
        return idx[2:0];
    endfunction

    task automatic req(input int s, input logic c, input logic w, input logic [4:0] idx);
        irq_req[s]          = 1'b1;
        irq_clr[s]          = c;
        irq_wait[s]         = w;
        irq_idx[s*5 +: 5]   = idx;
    endtask

    // Push the expected post-edge state, clock once, then pop and compare.
    task automatic cycle();
        exp_t       e, got;
        logic [7:0] setv, clrv, nf;
        logic [3:0] nw;
        logic [2:0] ni [4];
        logic [2:0] t;
        ni = m_idx;
        nw = m_wait;
        if (reset) begin
            nf = '0;
            nw = '0;
        end else begin
            setv = '0;
            clrv = host_clr;
            for (int s = 0; s < NUM_SM; s++) begin
                if (m_wait[s]) begin
                    if (!m_flags[m_idx[s]]) nw[s] = 1'b0;
                end else if (irq_req[s]) begin
                    t = tb_tgt(s, irq_idx[s*5 +: 5]);
                    if (irq_clr[s]) begin
                        clrv[t] = 1'b1;
                    end else begin
                        setv[t] = 1'b1;
                        if (irq_wait[s]) begin
                            nw[s] = 1'b1;
                            ni[s] = t;
                        end
                    end
                end
            end
            nf = setv | (m_flags & ~clrv);
        end
        e.f = nf;
        e.s = nw;
        e.o = |(nf[3:0] & irq_inten);
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        got = exp_q.pop_front();
        chk("sb_flags", 32'(irq_flags), 32'(got.f));
        chk("sb_stall", 32'(irq_stall), 32'(got.s));
        chk("sb_out",   32'(irq_out),   32'(got.o));
        m_flags  = nf;
        m_wait   = nw;
        m_idx    = ni;
        irq_req  = '0;
        irq_clr  = '0;
        irq_wait = '0;
        host_clr = '0;
    endtask

    initial begin
        for (int i = 0; i < 4; i++) m_idx[i] = '0;
        reset     = 1'b1;
        irq_req   = '0;
        irq_clr   = '0;
        irq_wait  = '0;
        irq_idx   = '0;
        host_clr  = '0;
        irq_inten = '0;
        @(posedge clk);
        #1;
        cycle();
        cycle();
        chk("rst_flags", 32'(irq_flags), 32'h0);
        chk("rst_stall", 32'(irq_stall), 32'h0);
        chk("rst_out",   32'(irq_out),   32'h0);
        reset = 1'b0;

        // Basic set / clear and host interrupt.
        irq_inten = 4'b1000;
        req(0, 1'b0, 1'b0, 5'b00011);
        cycle();
        chk("set_f3", 32'(irq_flags), 32'h08);
        chk("out_on", 32'(irq_out), 32'h1);
        req(1, 1'b1, 1'b0, 5'b00011);
        cycle();
        chk("clr_f3", 32'(irq_flags), 32'h00);
        chk("out_off", 32'(irq_out), 32'h0);

        // Relative addressing from SM2.
        req(2, 1'b0, 1'b0, 5'b10011);
        cycle();
`ifdef IRQ_REL_EN
        chk("rel_idx", 32'(irq_flags), 32'h02);
`else
        chk("rel_idx", 32'(irq_flags), 32'h08);
`endif
        host_clr = 8'hff;
        cycle();

        // Set-and-wait with host clear at cycle 10.
        req(0, 1'b0, 1'b1, 5'b00101);
        cycle();
        for (int c = 1; c < 10; c++) begin
            if (c == 4) req(0, 1'b0, 1'b0, 5'b00110);
            chk("wait_stall", 32'(irq_stall[0]), 32'h1);
            cycle();
        end
        chk("wait_ignored", 32'(irq_flags), 32'h20);
        host_clr = 8'h20;
        cycle();
        chk("hclr_f5", 32'(irq_flags[5]), 32'h0);
        chk("stall_c11", 32'(irq_stall[0]), 32'h1);
        cycle();
        chk("stall_c12", 32'(irq_stall[0]), 32'h0);

        // Set beats both machine and host clear.
        req(1, 1'b0, 1'b0, 5'b00010);
        req(3, 1'b1, 1'b0, 5'b00010);
        host_clr = 8'h04;
        cycle();
        chk("set_wins", 32'(irq_flags[2]), 32'h1);
        host_clr = 8'h04;
        cycle();

        // Two waiters on one flag; coincident set/clear keeps them stalled.
        req(0, 1'b0, 1'b1, 5'b00100);
        cycle();
        req(2, 1'b0, 1'b1, 5'b00100);
        cycle();
        req(1, 1'b1, 1'b0, 5'b00100);
        req(3, 1'b0, 1'b0, 5'b00100);
        cycle();
        chk("dual_hold", 32'(irq_stall), 32'h5);
        host_clr = 8'h10;
        cycle();
        cycle();
        chk("dual_rel", 32'(irq_stall), 32'h0);

        // Reset while SM3 waits on flag 7.
        req(3, 1'b0, 1'b1, 5'b00111);
        cycle();
        chk("sm3_wait", 32'(irq_stall[3]), 32'h1);
        reset = 1'b1;
        req(2, 1'b0, 1'b0, 5'b00001);
        cycle();
        chk("mid_rst_f", 32'(irq_flags), 32'h0);
        chk("mid_rst_s", 32'(irq_stall), 32'h0);
        reset = 1'b0;
        req(3, 1'b0, 1'b1, 5'b00111);
        cycle();
        chk("post_rst_s", 32'(irq_stall[3]), 32'h1);
        chk("post_rst_f", 32'(irq_flags), 32'h80);

        // Random traffic against the scoreboard model.
        for (int n = 0; n < 400; n++) begin
            reset     = ($urandom_range(0, 59) == 0);
            irq_inten = 4'($urandom);
            for (int s = 0; s < NUM_SM; s++) begin
                if ($urandom_range(0, 2) == 0)
                    req(s, 1'($urandom), 1'($urandom), 5'($urandom));
            end
            if ($urandom_range(0, 3) == 0) host_clr = 8'($urandom);
            cycle();
        end
        reset = 1'b0;
        chk("q_empty", 32'(exp_q.size()), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
